// File: rtl/display_scan_4x.sv
// Four-digit multiplexed hex display scanner with frame-synchronous value update
// and optional leading-zero blanking.
module display_scan_4x #(
  parameter int unsigned DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] num,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_done
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    sel;
  logic [15:0]   disp;
  logic [15:0]   pend;
  logic          pend_valid;
  logic          tick;
  logic          boundary;
  logic          blanked;
  logic [3:0]    lz;

  assign tick     = (cnt == CW'(DIV - 1));
  assign boundary = tick && (sel == 2'd3);
  assign pending  = pend_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      sel        <= '0;
      disp       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      frame_done <= boundary;
      if (tick)
        sel <= sel + 2'd1;
      // Transfer uses the registered pend; a coincident load lands afterwards
      // and leaves pend_valid set.
      if (boundary && pend_valid) begin
        disp       <= pend;
        pend_valid <= 1'b0;
      end
      if (load) begin
        pend       <= num;
        pend_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    bcd = disp[3:0];
    case (sel)
      2'd0: bcd = disp[3:0];
      2'd1: bcd = disp[7:4];
      2'd2: bcd = disp[11:8];
      2'd3: bcd = disp[15:12];
      default: bcd = disp[3:0];
    endcase
  end

  assign lz[0] = 1'b0;
  assign lz[1] = (disp[15:4]  == '0);
  assign lz[2] = (disp[15:8]  == '0);
  assign lz[3] = (disp[15:12] == '0);

  assign blanked = blank_lz && lz[sel];
  assign an      = blanked ? 4'b1111 : ~(4'b0001 << sel);

endmodule

// File: tb/tb_display_scan_4x.sv
// Scoreboard bench for display_scan_4x: a cycle-level reference model pushes
// expected outputs, a negedge monitor pops and compares.
module tb_display_scan_4x;

  localparam int unsigned DIV   = 4;
  localparam int unsigned FRAME = 4 * DIV;

  logic        clk;
  logic        rst;
  logic [15:0] num;
  logic        load;
  logic        blank_lz;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  display_scan_4x #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .num(num), .load(load), .blank_lz(blank_lz),
    .bcd(bcd), .an(an), .pending(pending), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] bcd;
    logic [3:0] an;
    logic       pend;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: time since reset release determines slot and frame edges.
  int unsigned m_t    = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  logic        m_pv   = 1'b0;
  logic        m_fd   = 1'b0;

  initial begin
    forever begin
      int unsigned slot;
      bit          is_boundary;
      bit          blank;
      exp_t        e;
      @(posedge clk);
      if (!rst) begin
        m_t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0; m_fd = 1'b0;
      end else begin
        is_boundary = ((m_t % FRAME) == FRAME - 1);
        m_fd = is_boundary;
        if (is_boundary && m_pv) begin
          m_disp = m_pend;
          m_pv   = 1'b0;
        end
        if (load) begin
          m_pend = num;
          m_pv   = 1'b1;
        end
        m_t = m_t + 1;
      end
      slot  = (m_t / DIV) % 4;
      blank = blank_lz && (slot != 0) && ((m_disp >> (4 * slot)) == 0);
      e.bcd  = 4'((m_disp >> (4 * slot)) & 16'hF);
      e.an   = blank ? 4'b1111 : 4'(15 - (1 << slot));
      e.pend = m_pv;
      e.fd   = m_fd;
      q.push_back(e);
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, req);
    end
  endtask

  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("bcd", bcd, e.bcd);
        chk("an", an, e.an);
        chk("pending", {3'b0, pending}, {3'b0, e.pend});
        chk("frame_done", {3'b0, frame_done}, {3'b0, e.fd});
      end
    end
  end

  task automatic drive(input logic r, input logic l, input logic [15:0] n, input logic b);
    rst = r; load = l; num = n; blank_lz = b;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b1, 1'b0, num, blank_lz);
  endtask

  task automatic wait_phase(input int unsigned p);
    for (int unsigned i = 0; i < FRAME && (m_t % FRAME) != p; i++)
      drive(1'b1, 1'b0, num, blank_lz);
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; num = '0; blank_lz = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b1, 16'hBEEF, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    idle(40);

    wait_phase(6);
    drive(1'b1, 1'b1, 16'h12AF, 1'b0);
    idle(40);

    drive(1'b1, 1'b1, 16'h0007, 1'b1);
    idle(40);
    drive(1'b1, 1'b0, 16'h0007, 1'b0);
    idle(20);

    wait_phase(2);
    drive(1'b1, 1'b1, 16'h1111, 1'b0);
    idle(3);
    drive(1'b1, 1'b1, 16'h2222, 1'b0);
    idle(40);

    wait_phase(3);
    drive(1'b1, 1'b1, 16'h1111, 1'b0);
    wait_phase(FRAME - 1);
    drive(1'b1, 1'b1, 16'h3333, 1'b0);
    idle(40);

    drive(1'b1, 1'b1, 16'h0450, 1'b1);
    wait_phase(9);
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    idle(40);

    for (int unsigned i = 0; i < 3000; i++) begin
      logic [15:0] n;
      logic        b;
      n = 16'($urandom);
      case ($urandom_range(3))
        0: n = n & 16'h000F;
        1: n = n & 16'h00FF;
        2: n = n & 16'h0FFF;
        default: ;
      endcase
      b = blank_lz;
      if ($urandom_range(19) == 0) b = ~b;
      drive(($urandom_range(149) != 0), ($urandom_range(7) == 0), n, b);
    end
    idle(2);

    total++;
    if (total < 4000) begin
      bad++;
      $display("FAIL monitor_starved: got %0d comparisons want >= 4000", total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan_4x.md
DISPLAY_SCAN_4X -- requirements
Module: display_scan_4x

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, giving clock cycles per digit slot; legal range DIV >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port num, input, 16 bits: four hex digits; num[3:0] is the rightmost digit (digit 0).
REQ-005 The block SHALL have port load, input, 1 bit: when high, num is captured into the pending register that cycle.
REQ-006 The block SHALL have port blank_lz, input, 1 bit: enables leading-zero blanking.
REQ-007 The block SHALL have port bcd, output, 4 bits: the nibble of the active digit, fed to the hex-to-7-segment decoder.
REQ-008 The block SHALL have port an, output, 4 bits: active-low one-hot digit enable; an[k] low selects digit k.
REQ-009 The block SHALL have port pending, output, 1 bit: high while a loaded value awaits the next frame boundary.
REQ-010 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse marking the start of each new scan frame.

Function
REQ-011 Prescaler cnt SHALL count 0..DIV-1 and wrap to 0; tick = (cnt == DIV-1).
REQ-012 Digit index sel (2 bits) SHALL advance by 1 on each tick and wrap 3 -> 0; it SHALL hold otherwise.
REQ-013 Digit k SHALL therefore be active for exactly DIV cycles; a full frame SHALL last 4*DIV cycles.
REQ-014 Registers SHALL be disp (16-bit displayed value), pend (16-bit), and pend_valid; pending SHALL equal pend_valid.
REQ-015 When load=1, pend SHALL take num and pend_valid SHALL be set; of back-to-back loads, the last one wins.
REQ-016 Frame boundary = tick with sel==3; on it, if pend_valid=1 (registered value), disp SHALL take pend and pend_valid SHALL clear.
REQ-017 If load=1 on a frame-boundary cycle, the transfer SHALL use the old pend; new num goes to pend and pend_valid SHALL end the cycle at 1.
REQ-018 disp SHALL never change except at a frame boundary, so no frame shows mixed values.
REQ-019 bcd SHALL equal disp[4*sel+3 : 4*sel], derived combinationally from registers, with no extra latency.
REQ-020 Digit k (k = 1..3) SHALL be blanked when blank_lz=1 and disp[15:4k] == 0; digit 0 SHALL never be blanked.
REQ-021 an SHALL be ~(4'b0001 << sel) when the active digit is not blanked, and 4'b1111 when it is blanked; bcd is unaffected by blanking.
REQ-022 frame_done SHALL be a register set for exactly one cycle, the cycle after a frame boundary (coincident with sel==0 first cycle).
REQ-023 blank_lz SHALL take effect combinationally on the current slot, without waiting for a frame boundary.

Reset
REQ-024 With rst=0 at a clock edge, the block SHALL set cnt=0, sel=0, disp=0, pend=0, pend_valid=0, and frame_done=0.
REQ-025 After reset, outputs SHALL be bcd=4'h0, an=4'b1110, pending=0, and frame_done=0.
REQ-026 Reset SHALL override load and tick in the same cycle; a pending value SHALL be discarded, and the scan SHALL restart from digit 0.

Verification (DIV=4)
REQ-027 Reset, then idle: an SHALL cycle 1110,1101,1011,0111 with 4 cycles each, and frame_done SHALL pulse every 16 cycles.
REQ-028 load=1 with num=16'h12AF mid-frame: pending=1 until the boundary. In the next frame, bcd SHALL be F,A,2,1 on digits 0..3, then pending=0.
REQ-029 num=16'h0007 loaded and blank_lz=1: an SHALL be 1110 in slot 0 and 1111 in slots 1..3. With blank_lz=0, all four digits SHALL be enabled and bcd=0 in slots 1..3.
REQ-030 Loads of 16'h1111 then 16'h2222 in one frame: the next frame SHALL show 2222 only.
REQ-031 load of 16'h3333 on the boundary cycle while 16'h1111 is pending: the next frame SHALL show 1111, pending SHALL stay 1, and the following frame SHALL show 3333.
REQ-032 rst=0 during slot 2 with a value pending: the next cycle SHALL give an=1110, bcd=0, pending=0, with no frame_done pulse.
